// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table and the all-off pattern.
// Glyph bits are active-low, [0]=a ... [6]=g.
package seg7_pkg;

    typedef logic [6:0] glyph_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // 6 and 9 use the tailed forms (segment a lit on 6, segment d lit on 9).
    localparam glyph_t GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble-to-glyph decoder, active-low segment outputs.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph_n
);

    assign glyph_n = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed seven-segment driver with shadowed inputs and a dead cycle per slot.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_TICKS = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int CNT_W = $clog2(SCAN_TICKS);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   point_q, point_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [3:0]          cur_nib;
    logic                cur_point;
    logic                cur_blank;
    logic [DIGITS-1:0]   lzb_mask;
    logic [6:0]          glyph_n;

    // Digit selection and optional leading-zero mask, both from the shadow registers.
    always_comb begin
        cur_nib   = 4'h0;
        cur_point = 1'b0;
        cur_blank = 1'b1;
        lzb_mask  = '0;
`ifdef SEG7_LZB_EN
        for (int i = DIGITS - 1; i > 0; i--) begin
            lzb_mask[i] = (hex_q[4*i +: 4] == 4'h0) && ((i == DIGITS - 1) || lzb_mask[i+1]);
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = hex_q[4*i +: 4];
                cur_point = point_q[i];
                cur_blank = blank_q[i] | lzb_mask[i];
            end
        end
    end

    hex7seg_dec u_dec (
        .nibble  (cur_nib),
        .glyph_n (glyph_n)
    );

    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        hex_d   = hex_q;
        point_d = point_q;
        blank_d = blank_q;
        seg_d   = SEG_OFF;
        an_d    = '1;

        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            hex_d   = hex_in;
            point_d = point_in;
            blank_d = blank_in;
        end

        // First cycle of every slot is dark so the previous digit cannot ghost.
        if (cnt_q != '0) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = {~cur_point, cur_blank ? 7'h7F : glyph_n};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            hex_q   <= '0;
            point_q <= '0;
            blank_q <= '1;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hex_q   <= hex_d;
            point_q <= point_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;

endmodule

// File: doc/seg7_scan_drv.md
SEG7_SCAN_DRV -- requirements
Module: seg7_scan_drv

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning the number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter SCAN_TICKS, default 100000, meaning clk cycles per digit slot; legal minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port load, input, 1 bit: capture the display inputs this cycle.
REQ-006 SHALL have port hex_in, input, 4*DIGITS bits: nibble i (bits 4i+3:4i) is the value for digit i.
REQ-007 SHALL have port point_in, input, DIGITS bits: 1 lights the decimal point of digit i.
REQ-008 SHALL have port blank_in, input, DIGITS bits: 1 forces segments a-g of digit i off.
REQ-009 SHALL have port seg_n, output, 8 bits, active-low: [0]=a … [6]=g, [7]=p.
REQ-010 SHALL have port an_n, output, DIGITS bits, active-low digit enables.

Function
REQ-011 SHALL copy hex_in, point_in and blank_in into shadow registers on the clock edge where load=1; shadows SHALL hold otherwise.
REQ-012 SHALL run a slot counter cnt from 0 to SCAN_TICKS-1 and wrap to 0; load SHALL NOT affect cnt or idx.
REQ-013 SHALL advance digit index idx by 1 on each cnt wrap, from DIGITS-1 to 0; idx SHALL stay 0 when DIGITS=1.
REQ-014 SHALL register seg_n and an_n, with the output in cycle k+1 a function of cnt, idx and shadows in cycle k.
REQ-015 SHALL drive an_n all-ones and seg_n 8'hFF in the cycle after cnt==0, as an anti-ghosting dead cycle.
REQ-016 SHALL otherwise drive an_n low only at bit idx, with seg_n[6:0] the active-low hex glyph of shadow nibble idx.
REQ-017 SHALL use these glyphs: 0-9 standard; A, b, C, d, E, F; 6 and 9 with tails (segments a and d lit, respectively).
REQ-018 SHALL force seg_n[6:0]=7'h7F when blank of digit idx is 1; seg_n[7] SHALL follow ~point independently of blank.
REQ-019 SHALL show a load in the same cycle as a slot change from the next non-dead slot output; a slot SHALL never mix old and new shadow values.

Reset
REQ-020 SHALL, while rst_n=0 at a clock edge, set cnt=0, idx=0, hex shadows 0, point shadows 0, blank shadows all-ones, seg_n=8'hFF and an_n all-ones.
REQ-021 SHALL give rst_n=0 priority over a simultaneous load.
REQ-022 SHALL restart a mid-slot reset at slot 0 on the first edge with rst_n=1.

Configuration
REQ-023 SHALL, with macro SEG7_LZB_EN defined, blank a-g of every digit i>0 whose nibble is 0 and whose higher digits are all 0 (leading-zero blanking).
REQ-024 SHALL never blank digit 0 under SEG7_LZB_EN, and the decimal point SHALL still follow point_in.
REQ-025 SHALL, without SEG7_LZB_EN, display only blank_in-driven blanking and contain no LZB logic.

Structure
REQ-026 SHALL place in shared package seg7_pkg: the 16-entry glyph constant table and constant SEG_OFF=8'hFF.
REQ-027 SHALL implement nibble-to-glyph decoding in one combinational sub-module hex7seg_dec (4-bit in, 7-bit active-low out), instantiated once on the idx-selected nibble.
REQ-028 SHALL compute cnt width as $clog2(SCAN_TICKS) and idx width as max(1,$clog2(DIGITS)).

Verification (DIGITS=4, SCAN_TICKS=4 unless stated)
REQ-029 SHALL verify: reset then release with no load -> an_n cycles 1110,1101,1011,0111 with one 1111 dead cycle per slot; seg_n[6:0]=7'h7F throughout.
REQ-030 SHALL verify: load hex_in=16'h3A0F, blank_in=0, point_in=4'b0100 -> digit0 seg_n=8'h8E (F), digit1 8'hC0 (0), digit2 8'h08 (A with point), digit3 8'hB0 (3).
REQ-031 SHALL verify: load asserted in the same cycle as cnt wrap -> the next slot shows new data with no mixed glyph; cnt and idx unperturbed.
REQ-032 SHALL verify: rst_n=0 mid-slot with load=1 -> outputs 8'hFF / 4'b1111, shadows reset, scan restarts at digit 0.
REQ-033 SHALL verify, with SEG7_LZB_EN: hex_in=16'h0050 -> digits 3 and 2 blank, digit1 shows 5, digit0 shows 0; hex_in=16'h0000 -> only digit0 lit.
REQ-034 SHALL verify: DIGITS=1, SCAN_TICKS=2 -> an_n alternates 1 (dead cycle) and 0 every cycle, with idx held at 0.
